if_fetch: RTL and testbench

Instruction-fetch stage of the RISC-V pipeline. It sits directly upstream of the IF/ID pipeline register and owns the PC. It fetches one 32-bit instruction per request over a req/ack instruction-memory port, and holds the fetched word until IF/ID accepts it. It also applies branch redirects and raises a stall request to the pipeline controller while no instruction is ready.

---
 rtl/if_fetch_pkg.sv | 29 ++
 rtl/if_fetch.sv | 111 +++++++++++
 tb/tb_if_fetch.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared bus widths, constants and fetch-FSM state encodings for the IF stage.
`default_nettype none

package if_fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  typedef logic [InstAddrBus-1:0] inst_addr_t;
  typedef logic [InstBus-1:0]     inst_t;

  localparam inst_t ZeroWord    = 32'h0000_0000;
  localparam logic  RstEnable_n = 1'b0;

  // Exported so the pipeline controller and benches can decode the fetch state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_READY = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  function automatic inst_addr_t word_align(input inst_addr_t a);
    return {a[InstAddrBus-1:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack port, buffers one
// instruction for IF/ID and applies branch redirects.
`default_nettype none

module if_fetch
  import if_fetch_pkg::*;
#(
  parameter inst_addr_t RESET_PC = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] stall,
  input  logic       branch_flag,
  input  inst_addr_t branch_target_addr,
  output logic       mem_req,
  output inst_addr_t mem_addr,
  input  logic       mem_ack,
  input  inst_t      mem_rdata,
  output inst_addr_t if_pc,
  output inst_t      if_inst,
  output logic       if_stallreq
);

  fetch_state_e state_q, state_d;
  inst_addr_t   pc_q, pc_d;
  inst_t        inst_buf_q, inst_buf_d;
  // Address of the request in flight; pc may already hold a redirect target.
  inst_addr_t   req_addr_q, req_addr_d;

  logic unused_inputs;
  assign unused_inputs = ^{stall[5:2], stall[0], branch_target_addr[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      inst_buf_q <= ZeroWord;
      req_addr_q <= ZeroWord;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_buf_q <= inst_buf_d;
      req_addr_q <= req_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_buf_d = inst_buf_q;
    req_addr_d = req_addr_q;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        req_addr_d = word_align(pc_q);
        if (mem_ack) begin
          inst_buf_d = mem_rdata;
          state_d    = ST_READY;
        end
      end
      ST_READY: begin
        if (!stall[1]) begin
          pc_d    = pc_q + 32'd4;
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (mem_ack) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase

    // Redirect overrides everything; an un-acked request must drain first.
    if (branch_flag) begin
      pc_d       = word_align(branch_target_addr);
      inst_buf_d = inst_buf_q;
      case (state_q)
        ST_FETCH, ST_DRAIN: state_d = mem_ack ? ST_FETCH : ST_DRAIN;
        default:            state_d = ST_FETCH;
      endcase
    end
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_addr    = ZeroWord;
    if_pc       = ZeroWord;
    if_inst     = ZeroWord;
    if_stallreq = 1'b1;
    case (state_q)
      ST_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = word_align(pc_q);
      end
      ST_DRAIN: begin
        mem_req  = 1'b1;
        mem_addr = req_addr_q;
      end
      ST_READY: begin
        if_pc       = pc_q;
        if_inst     = inst_buf_q;
        if_stallreq = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: vector table, directed corner cases and a
// randomized run against a behavioural model.
`default_nettype none

module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] XMASK    = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag;
  logic [31:0] branch_target_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_stallreq;

  if_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_flag(branch_flag), .branch_target_addr(branch_target_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .if_pc(if_pc), .if_inst(if_inst), .if_stallreq(if_stallreq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [97:0] act, input logic [97:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got req/addr/pc/inst/sreq=%h required %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [97:0] dut_out();
    return {mem_req, mem_addr, if_pc, if_inst, if_stallreq};
  endfunction

  // Behavioural model: "have an instruction", "discarding a stale reply", pc.
  logic        m_started, m_have, m_drain;
  logic [31:0] m_pc, m_buf, m_daddr;

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] m_addr();
    if (!m_started || m_have) return 32'h0;
    return m_drain ? m_daddr : align(m_pc);
  endfunction

  function automatic logic [97:0] m_out();
    if (!m_started) return {1'b0, 32'h0, 32'h0, 32'h0, 1'b1};
    if (m_have)     return {1'b0, 32'h0, m_pc, m_buf, 1'b0};
    return {1'b1, m_addr(), 64'h0, 1'b1};
  endfunction

  task automatic model_reset();
    m_started = 0; m_have = 0; m_drain = 0;
    m_pc = RESET_PC; m_buf = 0; m_daddr = 0;
  endtask

  task automatic model_edge(input logic br, input logic [31:0] tgt, input logic st1,
                            input logic ack, input logic [31:0] rdata);
    if (!m_started) begin
      m_started = 1;
      if (br) m_pc = align(tgt);
    end else if (m_have) begin
      if (br) begin m_pc = align(tgt); m_have = 0; end
      else if (!st1) begin m_pc = m_pc + 32'd4; m_have = 0; end
    end else if (br) begin
      if (!m_drain) m_daddr = align(m_pc);
      m_drain = !ack;
      m_pc = align(tgt);
    end else if (ack) begin
      if (m_drain) m_drain = 0;
      else begin m_have = 1; m_buf = rdata; end
    end
  endtask

  // Drive one cycle at the negedge, check mid-cycle, advance model at posedge.
  task automatic step(input string name, input logic br, input logic [31:0] tgt,
                      input logic st1, input logic ack);
    logic [31:0] rd;
    rd = m_addr() ^ XMASK;
    branch_flag = br; branch_target_addr = tgt;
    stall = {4'b0, st1, 1'b0};
    mem_ack = ack; mem_rdata = rd;
    #1 chk(name, dut_out(), m_out());
    @(posedge clk);
    model_edge(br, tgt, st1, ack, rd);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; stall = 0; branch_flag = 0; branch_target_addr = 0;
    mem_ack = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    #1 chk("reset_values", dut_out(), {1'b0, 32'h0, 32'h0, 32'h0, 1'b1});
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        st;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_sreq;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // Zero-wait stream from reset, then a 4-cycle READY hold at pc 0x10.
    tbl[0]  = '{0, 0, 32'h0,        0, 32'h00, 32'h00, 32'h0,        1};
    tbl[1]  = '{0, 1, 32'hA5A5A5A5, 1, 32'h00, 32'h00, 32'h0,        1};
    tbl[2]  = '{0, 0, 32'h0,        0, 32'h00, 32'h00, 32'hA5A5A5A5, 0};
    tbl[3]  = '{0, 1, 32'hA5A5A5A1, 1, 32'h04, 32'h00, 32'h0,        1};
    tbl[4]  = '{0, 0, 32'h0,        0, 32'h00, 32'h04, 32'hA5A5A5A1, 0};
    tbl[5]  = '{0, 1, 32'hA5A5A5AD, 1, 32'h08, 32'h00, 32'h0,        1};
    tbl[6]  = '{0, 0, 32'h0,        0, 32'h00, 32'h08, 32'hA5A5A5AD, 0};
    tbl[7]  = '{0, 1, 32'hA5A5A5A9, 1, 32'h0C, 32'h00, 32'h0,        1};
    tbl[8]  = '{0, 0, 32'h0,        0, 32'h00, 32'h0C, 32'hA5A5A5A9, 0};
    tbl[9]  = '{0, 1, 32'hA5A5A5B5, 1, 32'h10, 32'h00, 32'h0,        1};
    tbl[10] = '{1, 0, 32'h0,        0, 32'h00, 32'h10, 32'hA5A5A5B5, 0};
    tbl[11] = '{1, 0, 32'h0,        0, 32'h00, 32'h10, 32'hA5A5A5B5, 0};
    tbl[12] = '{1, 0, 32'h0,        0, 32'h00, 32'h10, 32'hA5A5A5B5, 0};
    tbl[13] = '{0, 0, 32'h0,        0, 32'h00, 32'h10, 32'hA5A5A5B5, 0};
    tbl[14] = '{0, 0, 32'h0,        1, 32'h14, 32'h00, 32'h0,        1};
    tbl[15] = '{0, 1, 32'hA5A5A5B1, 1, 32'h14, 32'h00, 32'h0,        1};
    tbl[16] = '{0, 0, 32'h0,        0, 32'h00, 32'h14, 32'hA5A5A5B1, 0};

    do_reset();
    for (int i = 0; i < 17; i++) begin
      stall = {4'b0, tbl[i].st, 1'b0};
      mem_ack = tbl[i].ack; mem_rdata = tbl[i].rdata;
      branch_flag = 0; branch_target_addr = 0;
      #1 chk($sformatf("table[%0d]", i), dut_out(),
             {tbl[i].e_req, tbl[i].e_addr, tbl[i].e_pc, tbl[i].e_inst, tbl[i].e_sreq});
      @(posedge clk);
      @(negedge clk);
    end

    // Redirect during a 3-wait-cycle request: old address held, data dropped.
    do_reset();
    step("br_wait_idle", 0, 0, 0, 0);
    step("br_wait_w0", 0, 0, 0, 0);
    step("br_wait_w1", 1, 32'h200, 0, 0);
    #1 chk("drain_old_addr", {mem_req, mem_addr, 65'h1}, {1'b1, 32'h0, 65'h1});
    step("br_wait_w2", 0, 0, 0, 0);
    step("br_wait_ack", 0, 0, 0, 1);
    #1 chk("drain_then_target", dut_out(), {1'b1, 32'h200, 64'h0, 1'b1});
    step("br_wait_tgt", 0, 0, 0, 1);
    step("br_wait_rdy", 0, 0, 0, 0);

    // Redirect with ack in the same cycle, unaligned target.
    step("br_ack_fetch", 0, 0, 0, 0);
    step("br_ack_same", 1, 32'h103, 0, 1);
    #1 chk("br_ack_next", dut_out(), {1'b1, 32'h100, 64'h0, 1'b1});
    step("br_ack_f2", 0, 0, 0, 1);

    // Redirect from READY while stalled: buffer dropped, no pc+4.
    step("br_rdy_hold", 0, 0, 1, 0);
    step("br_rdy_br", 1, 32'h300, 1, 0);
    #1 chk("br_rdy_next", dut_out(), {1'b1, 32'h300, 64'h0, 1'b1});
    step("br_rdy_f", 0, 0, 0, 1);

    // Asynchronous reset mid-FETCH and mid-READY.
    step("rst_fetch_pre", 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1 chk("rst_async_fetch", dut_out(), {1'b0, 32'h0, 32'h0, 32'h0, 1'b1});
    @(negedge clk);
    rst = 1'b1; model_reset();
    step("rst_restart_idle", 0, 0, 0, 0);
    step("rst_restart_fetch", 0, 0, 0, 1);
    step("rst_ready", 0, 0, 1, 0);
    #2 rst = 1'b0;
    #1 chk("rst_async_ready", dut_out(), {1'b0, 32'h0, 32'h0, 32'h0, 1'b1});
    @(negedge clk);
    rst = 1'b1; model_reset();

    // Randomized traffic against the model, including targets near the wrap point.
    for (int c = 0; c < 600; c++) begin
      logic        br, st1, ack;
      logic [31:0] tgt;
      br  = ($urandom_range(0, 7) == 0);
      st1 = ($urandom_range(0, 2) == 0);
      ack = ($urandom_range(0, 1) == 1);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step("random", br, tgt, st1, ack);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
